// File: rtl/jk_count_ctrl.sv
// jk_count_ctrl: handshaked up/down/load/hold modulo-MOD counter controller driving a JK flip-flop bank.
// Optional Q-vs-nxt result checker with sticky Err is enabled by defining JKCTRL_VERIFY_EN.
module jk_count_ctrl #(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic             CLK,
    input  logic             ClrN,
    input  logic             Start,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             Busy,
    output logic             Done,
    output logic             Wrap,
    output logic             Err
);
    typedef enum logic [1:0] {IDLE, CALC, APPLY, VERIFY} state_t;
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);
    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] load_q, load_d, cur_q, cur_d, nxt_q, nxt_d;
    logic             wrap_q, wrap_d;
    logic             cur_oor, up_wrap, dn_wrap;
    assign cur_oor = 32'(cur_q) >= MOD;
    assign up_wrap = cur_q >= TOP;
    assign dn_wrap = cur_q == '0 || cur_oor;
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        load_d  = load_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        wrap_d  = wrap_q;
        case (state_q)
            IDLE: if (Start) begin
                state_d = CALC;
                mode_d  = Mode;
                load_d  = LoadVal;
                cur_d   = Q;
            end
            CALC: begin
                state_d = APPLY;
                nxt_d   = mode_q == 2'b01 ? (up_wrap ? '0 : cur_q + 1'b1) :
                          mode_q == 2'b10 ? (dn_wrap ? TOP : cur_q - 1'b1) :
                          mode_q == 2'b11 ? WIDTH'(32'(load_q) % MOD) : cur_q;
                wrap_d  = (mode_q == 2'b01 && up_wrap) || (mode_q == 2'b10 && dn_wrap);
            end
            APPLY:   state_d = VERIFY;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (ClrN) begin
            state_q <= IDLE;
            mode_q  <= '0;
            load_q  <= '0;
            cur_q   <= '0;
            nxt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            load_q  <= load_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            wrap_q  <= wrap_d;
        end
    end
    // Set bits with J, clear bits with K; unchanged bits get J=K=0 so the bank holds them.
    assign J    = state_q == APPLY ? nxt_q & ~cur_q : '0;
    assign K    = state_q == APPLY ? ~nxt_q & cur_q : '0;
    assign Busy = state_q != IDLE;
    assign Done = state_q == VERIFY;
    assign Wrap = Done & wrap_q;
`ifdef JKCTRL_VERIFY_EN
    logic err_q, err_d;
    assign err_d = err_q | (Done && Q != nxt_q);
    always_ff @(posedge CLK) begin
        if (ClrN) err_q <= 1'b0;
        else      err_q <= err_d;
    end
    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif
endmodule

// File: tb/tb_jk_count_ctrl.sv
// tb_jk_count_ctrl: randomized self-checking bench for jk_count_ctrl driving a behavioural JK bank (MOD=10).
module tb_jk_count_ctrl;
    localparam int W = 4;
    localparam int M = 10;
    logic CLK = 1'b0;
    logic ClrN, Start, Busy, Done, Wrap, Err;
    logic [1:0] Mode;
    logic [W-1:0] LoadVal, Q, J, K;
    logic pre, stuck, exp_err;
    logic [W-1:0] pre_v;
    int n_cmp = 0;
    int n_bad = 0;

    jk_count_ctrl #(.WIDTH(W), .MOD(M)) dut (
        .CLK(CLK), .ClrN(ClrN), .Start(Start), .Mode(Mode), .LoadVal(LoadVal), .Q(Q),
        .J(J), .K(K), .Busy(Busy), .Done(Done), .Wrap(Wrap), .Err(Err)
    );

    always #5 CLK = ~CLK;

    // JK bank with a shared clear, a preload hook and a stuck-at fault hook.
    always @(posedge CLK) begin
        if (ClrN) Q <= '0;
        else if (stuck || pre) Q <= pre_v;
        else for (int i = 0; i < W; i++)
            Q[i] <= (J[i] && K[i]) ? ~Q[i] : J[i] ? 1'b1 : K[i] ? 1'b0 : Q[i];
    end

    function automatic logic [W:0] ref_op(input int cur, input logic [1:0] md, input int lv);
        case (md)
            2'b01:   return cur >= M - 1 ? {1'b1, 4'd0} : {1'b0, 4'(cur + 1)};
            2'b10:   return (cur == 0 || cur >= M) ? {1'b1, 4'(M - 1)} : {1'b0, 4'(cur - 1)};
            2'b11:   return {1'b0, 4'(lv % M)};
            default: return {1'b0, 4'(cur)};
        endcase
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_q(input logic [W-1:0] v);
        pre = 1'b1;
        pre_v = v;
        tick();
        pre = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] md, input logic [W-1:0] lv, input string tag);
        logic [W-1:0] cur, nx, expq;
        logic wr;
        cur = Q;
        {wr, nx} = ref_op(int'(cur), md, int'(lv));
        expq = stuck ? pre_v : nx;
        Start = 1'b1; Mode = md; LoadVal = lv;
        tick();
        Start = 1'b0; Mode = 2'($urandom); LoadVal = 4'($urandom);
        n_cmp++;
        if ({Busy, Done, Wrap, J, K} !== {3'b100, 8'h00}) begin
            n_bad++;
            $display("FAIL %s calc: got %h want %h", tag, {Busy, Done, Wrap, J, K}, {3'b100, 8'h00});
        end
        Start = 1'b1;
        tick();
        Start = 1'b0;
        n_cmp++;
        if ({Busy, Done, Wrap, J, K} !== {3'b100, nx & ~cur, ~nx & cur}) begin
            n_bad++;
            $display("FAIL %s apply: got %h want %h (cur %h nxt %h)", tag, {Busy, Done, Wrap, J, K},
                     {3'b100, nx & ~cur, ~nx & cur}, cur, nx);
        end
        tick();
        n_cmp++;
        if ({Busy, Done, Wrap, Err, Q} !== {2'b11, wr, exp_err, expq}) begin
            n_bad++;
            $display("FAIL %s verify: got %h want %h", tag, {Busy, Done, Wrap, Err, Q}, {2'b11, wr, exp_err, expq});
        end
        tick();
`ifdef JKCTRL_VERIFY_EN
        if (expq !== nx) exp_err = 1'b1;
`endif
        n_cmp++;
        if ({Busy, Done, Wrap, Err, J, K} !== {3'b000, exp_err, 8'h00}) begin
            n_bad++;
            $display("FAIL %s idle: got %h want %h", tag, {Busy, Done, Wrap, Err, J, K}, {3'b000, exp_err, 8'h00});
        end
    endtask

    task automatic test_reset;
        ClrN = 1'b1;
        tick();
        tick();
        ClrN = 1'b0;
        exp_err = 1'b0;
        n_cmp++;
        if ({Busy, Done, Wrap, Err, J, K, Q} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset: got %h want 0", {Busy, Done, Wrap, Err, J, K, Q});
        end
    endtask

    task automatic test_directed;
        set_q(4'd9);  run_op(2'b01, 4'd0, "up_wrap");
        set_q(4'd0);  run_op(2'b10, 4'd0, "down_wrap");
        set_q(4'd3);  run_op(2'b11, 4'd6, "load");
        set_q(4'd12); run_op(2'b01, 4'd0, "up_oor");
        set_q(4'd11); run_op(2'b10, 4'd0, "down_oor");
        set_q(4'd7);  run_op(2'b11, 4'd15, "load_mod");
        set_q(4'd6);  run_op(2'b00, 4'd3, "hold");
        set_q(4'd5);  run_op(2'b10, 4'd0, "down");
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) set_q(4'($urandom_range(0, 15)));
            run_op(2'($urandom), 4'($urandom), "rand");
        end
    endtask

    task automatic test_back_to_back;
        set_q(4'd0);
        Mode = 2'b01;
        Start = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick();
            Mode = 2'($urandom); LoadVal = 4'($urandom);
            n_cmp++;
            if ({Busy, Done} !== 2'b10) begin
                n_bad++;
                $display("FAIL b2b calc %0d: got %b want 10", n, {Busy, Done});
            end
            tick();
            tick();
            Mode = 2'b01;
            n_cmp++;
            if ({Done, Wrap, Q} !== {1'b1, n == 9, 4'((n + 1) % M)}) begin
                n_bad++;
                $display("FAIL b2b verify %0d: got %h want %h", n, {Done, Wrap, Q}, {1'b1, n == 9, 4'((n + 1) % M)});
            end
            tick();
            n_cmp++;
            if ({Busy, Done} !== 2'b00) begin
                n_bad++;
                $display("FAIL b2b idle %0d: got %b want 00", n, {Busy, Done});
            end
        end
        Start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        set_q(4'd4);
        Start = 1'b1; Mode = 2'b01;
        tick();
        Start = 1'b0;
        tick();
        ClrN = 1'b1;
        tick();
        ClrN = 1'b0;
        exp_err = 1'b0;
        n_cmp++;
        if ({Busy, Done, Wrap, Err, J, K, Q} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_mid: got %h want 0", {Busy, Done, Wrap, Err, J, K, Q});
        end
        tick();
        n_cmp++;
        if ({Busy, Done} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_mid late: got %b want 00", {Busy, Done});
        end
        run_op(2'b01, 4'd0, "post_reset");
    endtask

    task automatic test_err;
        set_q(4'd5);
        stuck = 1'b1;
        run_op(2'b01, 4'd0, "stuck1");
        run_op(2'b11, 4'd2, "stuck2");
        stuck = 1'b0;
        ClrN = 1'b1;
        tick();
        ClrN = 1'b0;
        exp_err = 1'b0;
        n_cmp++;
        if ({Err, Q} !== 5'h0) begin
            n_bad++;
            $display("FAIL err_clear: got %h want 0", {Err, Q});
        end
        run_op(2'b01, 4'd0, "after_err");
    endtask

    initial begin
        Start = 1'b0; Mode = '0; LoadVal = '0; pre = 1'b0; stuck = 1'b0; pre_v = '0;
        exp_err = 1'b0; ClrN = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
